// File: rtl/ofmap_drain_controller_pkg.sv
// Shared encodings for the ofmap drain path: FSM state codes and lane-index sizing.
package ofmap_drain_controller_pkg;

  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Entries the skid FIFO can hold; also the cap on occupancy + reads in flight.
  localparam int FIFO_DEPTH = 2;

  // Width of the lane index; a single-lane build still needs one bit.
  function automatic int lane_idx_w(input int array_width);
    return (array_width > 1) ? $clog2(array_width) : 1;
  endfunction

endpackage

// File: rtl/ofmap_drain_controller_skid_fifo.sv
// Two-entry FIFO that absorbs accumulation-buffer read data while the
// serializer is still walking the lanes of the previous entry.
module ofmap_skid_fifo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ofmap_drain_controller.sv
// Drains one tile of accumulation-buffer entries and serializes each entry's
// lanes onto a single valid/ready element stream.
module ofmap_drain_controller
  import ofmap_drain_controller_pkg::*;
#(
  parameter int OFMAP_WIDTH           = 32,
  parameter int ARRAY_WIDTH           = 4,
  parameter int OFMAP_BANK_ADDR_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [OFMAP_BANK_ADDR_WIDTH-1:0]   ofmap_max_adr_c,
  input  logic                               ofmap_db_empty_n,
  output logic                               ofmap_wb_ren,
  output logic [OFMAP_BANK_ADDR_WIDTH-1:0]   ofmap_wb_radr,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] ofmap_wb_rdata,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dout,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic                               tile_done,
  output logic                               busy
);

  localparam int LANE_W  = lane_idx_w(ARRAY_WIDTH);
  localparam int ENTRY_W = OFMAP_WIDTH * ARRAY_WIDTH;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(ARRAY_WIDTH - 1);

  logic [STATE_W-1:0]               state_q, state_d;
  logic [OFMAP_BANK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OFMAP_BANK_ADDR_WIDTH-1:0] tile_max_q, tile_max_d;
  logic [LANE_W-1:0]                lane_q, lane_d;
  logic                             inflight_q;
  logic                             tile_done_q, tile_done_d;

  logic [ENTRY_W-1:0]                         fifo_head;
  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]    head_lanes;
  logic [1:0]                                 fifo_cnt;
  logic                                       ren;
  logic                                       xfer;
  logic                                       pop;

  // Read only while the bank has data and the FIFO can take every read already issued.
  assign ren  = (state_q == ST_DRAIN) && ofmap_db_empty_n &&
                ((fifo_cnt + {1'b0, inflight_q}) < 2'(FIFO_DEPTH));
  assign xfer = ofmap_vld && ofmap_rdy;
  assign pop  = xfer && (lane_q == LANE_LAST);

  ofmap_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (ofmap_wb_rdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  // Tile sequencing: latch the bound on entry, walk addresses, then wait for the FIFO to drain.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tile_max_d  = tile_max_q;
    tile_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ofmap_db_empty_n) begin
          state_d    = ST_DRAIN;
          tile_max_d = ofmap_max_adr_c;
          addr_d     = '0;
        end
      end
      ST_DRAIN: begin
        if (ren) begin
          addr_d = addr_q + OFMAP_BANK_ADDR_WIDTH'(1);
          if (addr_q == tile_max_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Empty FIFO with nothing in flight means the last element has left.
        if ((fifo_cnt == 2'd0) && !inflight_q) begin
          state_d     = ST_IDLE;
          tile_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane pointer advances on every transfer and wraps when the head entry is popped.
  always_comb begin
    lane_d = lane_q;
    if (xfer) lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + LANE_W'(1);
  end

  // State registers; reset also drops any read in flight so its data is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      tile_max_q  <= '0;
      lane_q      <= '0;
      inflight_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tile_max_q  <= tile_max_d;
      lane_q      <= lane_d;
      inflight_q  <= ren;
      tile_done_q <= tile_done_d;
    end
  end

  assign head_lanes    = fifo_head;
  assign ofmap_vld     = (fifo_cnt != 2'd0);
  assign ofmap_dout    = ofmap_vld ? head_lanes[lane_q] : '0;
  assign ofmap_wb_ren  = ren;
  assign ofmap_wb_radr = addr_q;
  assign tile_done     = tile_done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ofmap_drain_controller.sv
// Directed bench for ofmap_drain_controller with a queue-based reference model.
module tb_ofmap_drain_controller;

  localparam int OW  = 32;
  localparam int AW  = 4;
  localparam int ABW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ABW-1:0]    ofmap_max_adr_c;
  logic              ofmap_db_empty_n;
  logic              ofmap_wb_ren;
  logic [ABW-1:0]    ofmap_wb_radr;
  logic [OW*AW-1:0]  ofmap_wb_rdata;
  logic [OW-1:0]     ofmap_dout;
  logic              ofmap_vld;
  logic              ofmap_rdy;
  logic              tile_done;
  logic              busy;

  ofmap_drain_controller #(
    .OFMAP_WIDTH(OW), .ARRAY_WIDTH(AW), .OFMAP_BANK_ADDR_WIDTH(ABW)
  ) dut (
    .clk(clk), .rst(rst), .ofmap_max_adr_c(ofmap_max_adr_c),
    .ofmap_db_empty_n(ofmap_db_empty_n), .ofmap_wb_ren(ofmap_wb_ren),
    .ofmap_wb_radr(ofmap_wb_radr), .ofmap_wb_rdata(ofmap_wb_rdata),
    .ofmap_dout(ofmap_dout), .ofmap_vld(ofmap_vld), .ofmap_rdy(ofmap_rdy),
    .tile_done(tile_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bank contents: each element encodes tile tag, address and lane.
  function automatic logic [OW-1:0] elem(input int tg, input int a, input int k);
    return {8'(tg), 8'(a), 8'(k), 8'hA5};
  endfunction

  // ---------------- reference model state ----------------
  int tag = 0;
  int m_max = 0;
  logic [OW-1:0] exp_q[$];
  int exp_addr = 0, outs_cur = 0;
  int done_due = 0, due_cyc = 0, done_cnt = 0, done_cyc = -100;
  int first_ren_cyc = 0, first_vld_seen = 0, first_vld_cyc = 0, last_xfer_cyc = 0;
  int ren_gap = 0, post_rst = 0, prev_stall = 0;
  logic [OW-1:0] prev_dout, t_first_cur;
  int t_strobes = 0, t_outs = 0, t_lat = 0, t_span = 0;
  logic [OW-1:0] t_first;
  int addr_log[16];

  // Bank read port: data valid the cycle after the strobe, junk otherwise.
  initial begin
    logic lr; logic [ABW-1:0] la; int lt;
    ofmap_wb_rdata = '0;
    forever begin
      @(negedge clk);
      lr = ofmap_wb_ren; la = ofmap_wb_radr; lt = tag;
      @(posedge clk); #1;
      if (lr) for (int k = 0; k < AW; k++) ofmap_wb_rdata[k*OW +: OW] = elem(lt, int'(la), k);
      else ofmap_wb_rdata = {AW{32'hDEADBEEF}};
    end
  end

  // Compare process: one pass per cycle, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); exp_addr = 0; outs_cur = 0; done_due = 0;
      first_vld_seen = 0; prev_stall = 0; post_rst = 1;
    end else begin
      if (post_rst != 0) begin
        chk("rst_ren", ofmap_wb_ren, 0);   chk("rst_radr", ofmap_wb_radr, 0);
        chk("rst_vld", ofmap_vld, 0);      chk("rst_dout", ofmap_dout, 0);
        chk("rst_busy", busy, 0);          chk("rst_tile_done", tile_done, 0);
        post_rst = 0;
      end
      if (ofmap_wb_ren) begin
        chk("ren_needs_data", ofmap_db_empty_n, 1);
        chk("radr", ofmap_wb_radr, ABW'(exp_addr));
        chk("read_in_range", exp_addr <= m_max, 1);
        if (exp_addr == 0) begin first_ren_cyc = cyc; ren_gap = cyc - done_cyc; end
        if (exp_addr < 16) addr_log[exp_addr] = int'(ofmap_wb_radr);
        for (int k = 0; k < AW; k++) exp_q.push_back(elem(tag, exp_addr, k));
        exp_addr++;
      end
      chk("outstanding_le2", ((exp_q.size() + AW - 1) / AW) <= 2, 1);
      if (prev_stall != 0) begin
        chk("hold_vld", ofmap_vld, 1);
        chk("hold_dout", ofmap_dout, prev_dout);
      end
      if (exp_q.size() == 0) chk("vld_without_data", ofmap_vld, 0);
      if (ofmap_vld) begin
        if (first_vld_seen == 0) begin
          first_vld_seen = 1; first_vld_cyc = cyc; t_lat = cyc - first_ren_cyc;
          chk("first_vld_latency", cyc - first_ren_cyc, 2);
        end
        if (exp_q.size() > 0) begin
          chk("dout", ofmap_dout, exp_q[0]);
          if (ofmap_rdy) begin
            if (outs_cur == 0) t_first_cur = ofmap_dout;
            void'(exp_q.pop_front());
            outs_cur++; last_xfer_cyc = cyc;
            if (exp_q.size() == 0 && exp_addr == m_max + 1) begin done_due = 1; due_cyc = cyc; end
          end
        end
      end
      prev_stall = (ofmap_vld && !ofmap_rdy) ? 1 : 0;
      prev_dout  = ofmap_dout;
      if (tile_done) begin
        chk("tile_done_expected", done_due, 1);
        if (done_due != 0) chk("tile_done_timing", (cyc - due_cyc >= 1) && (cyc - due_cyc <= 2), 1);
        t_strobes = exp_addr; t_outs = outs_cur; t_first = t_first_cur;
        t_span = last_xfer_cyc - first_vld_cyc;
        done_cnt++; done_cyc = cyc; done_due = 0;
        exp_addr = 0; outs_cur = 0; first_vld_seen = 0;
      end else if (done_due != 0 && cyc - due_cyc > 2) begin
        chk("tile_done_missing", tile_done, 1);
        done_due = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One tile: alt toggles rdy, pause_at drops empty_n for 5 cycles after that many reads,
  // chg_max disturbs ofmap_max_adr_c once the tile is running.
  task automatic run_tile(input int mx, input int tg, input int alt, input int pause_at, input int chg_max);
    int d0, n, paused;
    ofmap_max_adr_c = ABW'(mx); m_max = mx; tag = tg;
    ofmap_db_empty_n = 1'b1; d0 = done_cnt; n = 0; paused = 0;
    while (done_cnt == d0 && n < 600) begin
      ofmap_rdy = (alt != 0) ? n[0] : 1'b1;
      if (chg_max != 0 && exp_addr >= 1) ofmap_max_adr_c = ABW'(mx + 5);
      if (pause_at >= 0 && paused == 0 && exp_addr == pause_at) begin
        paused = 1; ofmap_db_empty_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick(); n++;
          ofmap_rdy = (alt != 0) ? n[0] : 1'b1;
        end
        ofmap_db_empty_n = 1'b1;
      end
      if (exp_addr == mx + 1) ofmap_db_empty_n = 1'b0;
      tick(); n++;
    end
    chk("tile_done_seen", done_cnt != d0, 1);
    ofmap_db_empty_n = 1'b0; ofmap_rdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, n;
    rst = 1'b1; ofmap_db_empty_n = 1'b0; ofmap_rdy = 1'b0; ofmap_max_adr_c = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("init_busy", busy, 0); chk("init_vld", ofmap_vld, 0);
    chk("init_ren", ofmap_wb_ren, 0); chk("init_dout", ofmap_dout, 0);

    // Full-rate tile, max disturbed mid-tile.
    run_tile(3, 1, 0, -1, 1);
    chk("t1_strobes", t_strobes, 4);   chk("t1_outs", t_outs, 16);
    chk("t1_latency", t_lat, 2);       chk("t1_span", t_span, 15);
    chk("t1_first", t_first, 32'h010000A5); chk("t1_addr3", addr_log[3], 3);
    chk("t1_idle_busy", busy, 0);

    // Backpressure every other cycle.
    run_tile(3, 2, 1, -1, 0);
    chk("t2_strobes", t_strobes, 4);   chk("t2_outs", t_outs, 16);

    // Bank goes empty after two reads.
    run_tile(3, 3, 0, 2, 0);
    chk("t3_addr2", addr_log[2], 2);   chk("t3_outs", t_outs, 16);

    // Single-entry tile.
    run_tile(0, 4, 0, -1, 0);
    chk("t4_strobes", t_strobes, 1);   chk("t4_outs", t_outs, 4);
    chk("t4_first", t_first, 32'h040000A5);

    // Reset with a read in flight.
    ofmap_max_adr_c = 8'd3; m_max = 3; tag = 5; ofmap_db_empty_n = 1'b1; ofmap_rdy = 1'b1;
    n = 0;
    while (exp_addr < 1 && n < 20) begin tick(); n++; end
    chk("t5_read_started", exp_addr >= 1, 1);
    rst = 1'b1; ofmap_db_empty_n = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_vld", ofmap_vld, 0);   chk("t5_dout", ofmap_dout, 0);
    chk("t5_ren", ofmap_wb_ren, 0); chk("t5_radr", ofmap_wb_radr, 0);
    chk("t5_busy", busy, 0);       chk("t5_tile_done", tile_done, 0);
    repeat (4) tick();
    run_tile(1, 6, 0, -1, 0);
    chk("t6_strobes", t_strobes, 2); chk("t6_outs", t_outs, 8);
    chk("t6_first", t_first, 32'h060000A5);

    // Back-to-back tiles with the bank staying non-empty across tile_done.
    ofmap_max_adr_c = 8'd1; m_max = 1; tag = 7; ofmap_db_empty_n = 1'b1; ofmap_rdy = 1'b1;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 200) begin tick(); n++; end
    chk("t7_first_done", done_cnt != d0, 1);
    tag = 8;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 200) begin
      if (exp_addr == 2) ofmap_db_empty_n = 1'b0;
      tick(); n++;
    end
    chk("t8_done", done_cnt != d0, 1);
    ofmap_db_empty_n = 1'b0;
    chk("t8_gap", ren_gap <= 2, 1);
    chk("t8_first", t_first, 32'h080000A5);
    chk("t8_strobes", t_strobes, 2);
    repeat (3) tick();
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
